// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction fetch front end with prefetch queue and redirect
module mips_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              romCe,
  output logic [ADDR_W-1:0] instAddr,
  input  logic [31:0]       instruction,
  input  logic              jCe,
  input  logic [ADDR_W-1:0] jAddr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetchPc;
  logic              inflight;
  logic              drop;
  logic [ADDR_W-1:0] qPc [DEPTH];
  logic [31:0]       qWord [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] headPc;
  logic [31:0]       headData;

  logic              pop;
  logic              push;
  logic [CNT_W:0]    credit;
  logic [CNT_W-1:0]  cntAfterPop;
  logic [PTR_W-1:0]  rdNext;
  logic              unusedJLow;

  assign unusedJLow = ^jAddr[1:0];

  assign inst_valid  = (count != '0);
  assign inst_data   = headData;
  assign inst_pc     = headPc;
  assign pop         = inst_valid & inst_ready;
  // A redirect flushes the word returning this cycle along with the queue.
  assign push        = inflight & ~drop & ~jCe;
  assign credit      = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign romCe       = ~rst & ~jCe & (credit < (CNT_W+1)'(DEPTH));
  assign instAddr    = rst ? RESET_PC : pc;
  assign cntAfterPop = count - CNT_W'(pop);
  assign rdNext      = rdPtr + PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      qPc[wrPtr]   <= fetchPc;
      qWord[wrPtr] <= instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      fetchPc  <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      headPc   <= '0;
      headData <= '0;
    end else begin
      inflight <= romCe;
      if (romCe) begin
        pc      <= pc + ADDR_W'(4);
        fetchPc <= pc;
      end
      if (jCe) begin
        pc    <= {jAddr[ADDR_W-1:2], 2'b00};
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
        drop  <= inflight;
      end else begin
        drop  <= 1'b0;
        rdPtr <= rdNext;
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        count <= cntAfterPop + CNT_W'(push);
        // Head register tracks the entry that will sit at rdNext after this edge.
        if (push && cntAfterPop == '0) begin
          headPc   <= fetchPc;
          headData <= instruction;
        end else if (cntAfterPop != '0) begin
          headPc   <= qPc[rdNext];
          headData <= qWord[rdNext];
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && cntAfterPop == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed vector bench for mips_fetch_unit
module tb_mips_fetch_unit;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        jCe;
    logic [31:0] jAddr;
    logic        ready;
    logic        expCe;
    logic [31:0] expAddr;
    logic        expValid;
    int          hd;
    logic [31:0] expPc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aRst, aCe, aJCe, aValid, aReady;
  logic [31:0] aAddr, aInstr, aJAddr, aData, aPc;
  logic        bRst, bCe, bJCe, bValid, bReady;
  logic [7:0]  bAddr, bJAddr, bPc;
  logic [31:0] bInstr, bData;

  int nChecks = 0;
  int nFail = 0;
  vec_t vecs[$];

  function automatic logic [31:0] romWord(logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  always @(posedge clk) aInstr <= romWord(aAddr);
  always @(posedge clk) bInstr <= romWord({24'h0, bAddr});

  mips_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h100)) uA (
    .clk(clk), .rst(aRst), .romCe(aCe), .instAddr(aAddr), .instruction(aInstr),
    .jCe(aJCe), .jAddr(aJAddr), .inst_valid(aValid), .inst_ready(aReady),
    .inst_data(aData), .inst_pc(aPc)
  );

  mips_fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'hF8)) uB (
    .clk(clk), .rst(bRst), .romCe(bCe), .instAddr(bAddr), .instruction(bInstr),
    .jCe(bJCe), .jAddr(bJAddr), .inst_valid(bValid), .inst_ready(bReady),
    .inst_data(bData), .inst_pc(bPc)
  );

  function automatic vec_t mk(logic sel, logic rst, logic jCe, logic [31:0] jAddr, logic ready,
                              logic ce, logic [31:0] addr, logic v, int hd, logic [31:0] pcv);
    vec_t t;
    t.sel = sel; t.rst = rst; t.jCe = jCe; t.jAddr = jAddr; t.ready = ready;
    t.expCe = ce; t.expAddr = addr; t.expValid = v; t.hd = hd; t.expPc = pcv;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // DEPTH=4, RESET_PC=0x100: stream, backpressure, redirects
    vecs.push_back(mk(0, 1, 0, 0,        1, 0, 32'h100,  0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h100,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h104,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h108,  1, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h10C,  1, 1, 32'h104));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h110,  1, 1, 32'h108));
    vecs.push_back(mk(0, 0, 0, 0,        0, 1, 32'h114,  1, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 0,        0, 1, 32'h118,  1, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 32'h11C,  1, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 32'h11C,  1, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h11C,  1, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h120,  1, 1, 32'h110));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h124,  1, 1, 32'h114));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h128,  1, 1, 32'h118));
    vecs.push_back(mk(0, 0, 1, 32'h2002, 1, 0, 32'h12C,  1, 1, 32'h11C));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h2004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h2008, 1, 1, 32'h2000));
    vecs.push_back(mk(0, 0, 1, 32'h3000, 1, 0, 32'h200C, 1, 1, 32'h2004));
    vecs.push_back(mk(0, 0, 1, 32'h4008, 1, 0, 32'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h4008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h400C, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h4010, 1, 1, 32'h4008));
    vecs.push_back(mk(0, 0, 0, 0,        1, 1, 32'h4014, 1, 1, 32'h400C));
    // ADDR_W=8, DEPTH=2, RESET_PC=0xF8: wrap, full rate, reset with credits exhausted
    vecs.push_back(mk(1, 1, 0, 0,        1, 0, 32'hF8,   0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'hF8,   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'hFC,   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h00,   1, 1, 32'hF8));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h04,   1, 1, 32'hFC));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h08,   1, 1, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h0C,   1, 1, 32'h04));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0, 32'hF8,   1, 1, 32'h08));
    vecs.push_back(mk(1, 0, 0, 0,        0, 1, 32'hF8,   0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'hFC,   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h00,   1, 1, 32'hF8));
    vecs.push_back(mk(1, 0, 0, 0,        1, 1, 32'h04,   1, 1, 32'hFC));

    aRst = 1; aJCe = 0; aJAddr = 0; aReady = 1;
    bRst = 1; bJCe = 0; bJAddr = 0; bReady = 1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      logic        ce, v;
      logic [31:0] addr, pcv, dat;
      if (vecs[i].sel == 1'b0) begin
        aRst = vecs[i].rst; aJCe = vecs[i].jCe; aJAddr = vecs[i].jAddr; aReady = vecs[i].ready;
        bRst = 1;
      end else begin
        bRst = vecs[i].rst; bJCe = vecs[i].jCe; bJAddr = vecs[i].jAddr[7:0]; bReady = vecs[i].ready;
        aRst = 1; aJCe = 0;
      end
      @(negedge clk);
      if (vecs[i].sel == 1'b0) begin
        ce = aCe; addr = aAddr; v = aValid; pcv = aPc; dat = aData;
      end else begin
        ce = bCe; addr = {24'h0, bAddr}; v = bValid; pcv = {24'h0, bPc}; dat = bData;
      end
      chk($sformatf("row%0d romCe", i), {31'h0, ce}, {31'h0, vecs[i].expCe});
      chk($sformatf("row%0d instAddr", i), addr, vecs[i].expAddr);
      chk($sformatf("row%0d inst_valid", i), {31'h0, v}, {31'h0, vecs[i].expValid});
      if (vecs[i].hd == 1) begin
        chk($sformatf("row%0d inst_pc", i), pcv, vecs[i].expPc);
        chk($sformatf("row%0d inst_data", i), dat, romWord(vecs[i].expPc));
      end else if (vecs[i].hd == 2) begin
        chk($sformatf("row%0d inst_pc_rst", i), pcv, 32'h0);
        chk($sformatf("row%0d inst_data_rst", i), dat, 32'h0);
      end
      @(posedge clk);
      #1;
    end

    // Restart after a mid-stream reset: first word must be RESET_PC within a bounded wait
    aRst = 0; aReady = 0; aJCe = 0; bRst = 1;
    repeat (5) @(posedge clk);
    #1;
    aRst = 1;
    @(posedge clk);
    #1;
    aRst = 0; aReady = 1;
    begin
      int waited = 0;
      while (!aValid && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("restart_latency", waited, 2);
      chk("restart_pc", aPc, 32'h100);
      chk("restart_data", aData, romWord(32'h100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
